// File: rtl/mc_riscv_core.sv
// rtl/mc_riscv_core.sv - parametrised multicycle RISC-V core (rv64i subset) with stallable memory port
module mc_riscv_core #(
   parameter int              XLEN     = 64,
   parameter int              NREGS    = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              PC_STEP  = 4
) (
   input  logic            clock,
   input  logic            reset,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ready,
   input  logic [XLEN-1:0] mem_rdata,
   output logic [XLEN-1:0] pc,
   output logic            retire,
   output logic [XLEN-1:0] instret,
   output logic            halt
);
   localparam int              RW   = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
   state_t state, state_nx;

   logic [31:0]     ir;
   logic [XLEN-1:0] a, b, aluout, mdr, alu_res;
   logic [XLEN-1:0] rf [NREGS];

   logic [6:0]      opcode, funct7;
   logic [2:0]      funct3;
   logic [RW-1:0]   rs1, rs2, rd;
   logic [XLEN-1:0] imm_i, imm_s, imm_b;
   logic            is_r, is_addi, is_ld, is_sd, is_beq, legal;

   assign opcode = ir[6:0];
   assign funct3 = ir[14:12];
   assign funct7 = ir[31:25];
   // register index is the IR field taken modulo NREGS
   assign rs1    = ir[15 +: RW];
   assign rs2    = ir[20 +: RW];
   assign rd     = ir[7 +: RW];

   assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
   assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

   assign is_r    = (opcode == 7'b0110011) &&
                    (((funct7 == 7'b0000000) &&
                      ((funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111))) ||
                     ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
   assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
   assign is_ld   = (opcode == 7'b0000011) && (funct3 == 3'b011);
   assign is_sd   = (opcode == 7'b0100011) && (funct3 == 3'b011);
   assign is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
   assign legal   = is_r || is_addi || is_ld || is_sd || is_beq;

   always_comb begin
      alu_res = a + imm_i;
      if (is_r) begin
         if (funct7[5])                alu_res = a - b;
         else if (funct3 == 3'b111)    alu_res = a & b;
         else if (funct3 == 3'b110)    alu_res = a | b;
         else                          alu_res = a + b;
      end
   end

   always_comb begin
      state_nx  = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc;
      mem_wdata = b;
      retire    = 1'b0;
      case (state)
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) state_nx = DECODE;
         end
         DECODE: state_nx = legal ? EXEC : HALT;
         EXEC: begin
            if (is_beq) begin
               retire   = 1'b1;
               state_nx = FETCH;
            end else if (is_ld || is_sd) begin
               state_nx = MEM;
            end else begin
               state_nx = WB;
            end
         end
         MEM: begin
            mem_req  = 1'b1;
            mem_we   = is_sd;
            mem_addr = aluout;
            if (mem_ready) begin
               if (is_sd) begin
                  retire   = 1'b1;
                  state_nx = FETCH;
               end else begin
                  state_nx = WB;
               end
            end
         end
         WB: begin
            retire   = 1'b1;
            state_nx = FETCH;
         end
         HALT:    state_nx = HALT;
         default: state_nx = FETCH;
      endcase
      // outputs are forced quiet the moment reset asserts, independent of the clock
      if (!reset) begin
         mem_req = 1'b0;
         retire  = 1'b0;
      end
   end

   assign halt = (state == HALT);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= FETCH;
         pc      <= RESET_PC;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         aluout  <= '0;
         mdr     <= '0;
         instret <= '0;
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else begin
         state <= state_nx;
         if (retire) instret <= instret + XLEN'(1);
         case (state)
            FETCH: begin
               if (mem_ready) begin
                  ir <= mem_rdata[31:0];
                  pc <= pc + STEP;
               end
            end
            DECODE: begin
               a      <= rf[rs1];
               b      <= rf[rs2];
               aluout <= pc - STEP + imm_b;
               if (!legal) pc <= pc - STEP;
            end
            EXEC: begin
               if (is_beq) begin
                  if (a == b) pc <= aluout;
               end else if (is_ld) begin
                  aluout <= a + imm_i;
               end else if (is_sd) begin
                  aluout <= a + imm_s;
               end else begin
                  aluout <= alu_res;
               end
            end
            MEM: if (mem_ready && is_ld) mdr <= mem_rdata;
            WB:  if (rd != '0) rf[rd] <= is_ld ? mdr : aluout;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mc_riscv_core.sv
// tb/tb_mc_riscv_core.sv - randomized self-checking bench for mc_riscv_core against an instruction-level model
module tb_mc_riscv_core;
   logic clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   logic        rst64 = 1'b0, rst32 = 1'b0, sel32 = 1'b0;
   logic        mem_ready = 1'b0;
   logic [63:0] mem_rdata = '0;

   logic        req64, we64, retire64, halt64;
   logic [63:0] addr64, wdata64, pc64, instret64;
   logic        req32, we32, retire32, halt32;
   logic [31:0] addr32, wdata32, pc32, instret32;

   mc_riscv_core #(.XLEN(64), .NREGS(32), .PC_STEP(4)) dut64 (
      .clock(clock), .reset(rst64), .mem_req(req64), .mem_we(we64), .mem_addr(addr64),
      .mem_wdata(wdata64), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc(pc64),
      .retire(retire64), .instret(instret64), .halt(halt64));

   mc_riscv_core #(.XLEN(32), .NREGS(8), .PC_STEP(4)) dut32 (
      .clock(clock), .reset(rst32), .mem_req(req32), .mem_we(we32), .mem_addr(addr32),
      .mem_wdata(wdata32), .mem_ready(mem_ready), .mem_rdata(mem_rdata[31:0]), .pc(pc32),
      .retire(retire32), .instret(instret32), .halt(halt32));

   logic        m_req, m_we, m_retire, m_halt;
   logic [63:0] m_addr, m_wdata, m_pc, m_instret;
   assign m_req     = sel32 ? req32 : req64;
   assign m_we      = sel32 ? we32 : we64;
   assign m_retire  = sel32 ? retire32 : retire64;
   assign m_halt    = sel32 ? halt32 : halt64;
   assign m_addr    = sel32 ? {32'b0, addr32} : addr64;
   assign m_wdata   = sel32 ? {32'b0, wdata32} : wdata64;
   assign m_pc      = sel32 ? {32'b0, pc32} : pc64;
   assign m_instret = sel32 ? {32'b0, instret32} : instret64;

   // unified word-per-address memory with configurable wait states (-1 = random 0..3)
   logic [63:0] mem [logic [63:0]];
   logic [63:0] ref_mem [logic [63:0]];
   logic [63:0] ref_r [32];
   logic [63:0] ref_pc;
   int          fetch_waits = 0, data_waits = 0, waits_left = 0, stable_err = 0;
   logic [63:0] data_base = 64'h100, probe_addr = '1;
   logic        busy = 1'b0, last_we = 1'b0;
   logic [63:0] last_addr = '0, last_wdata = '0;

   always @(negedge clock) begin
      if (m_req) begin
         if (busy && (m_addr !== last_addr || m_we !== last_we || m_wdata !== last_wdata))
            stable_err++;
         if (!busy) begin
            busy = 1'b1;
            if (m_addr >= data_base)
               waits_left = (data_waits < 0) ? int'($urandom_range(0, 3)) : data_waits;
            else
               waits_left = (fetch_waits < 0) ? int'($urandom_range(0, 3)) : fetch_waits;
         end
         last_addr = m_addr; last_we = m_we; last_wdata = m_wdata;
         if (waits_left == 0) begin
            mem_ready = 1'b1;
            busy = 1'b0;
            if (m_we) mem[m_addr] = m_wdata;
            mem_rdata = mem.exists(m_addr) ? mem[m_addr] : 64'h0;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = {$urandom, $urandom};
            waits_left--;
         end
      end else begin
         busy = 1'b0;
         mem_ready = 1'($urandom_range(0, 1));
         mem_rdata = {$urandom, $urandom};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
      return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
   endfunction

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic do_reset(input logic use32);
      sel32 = use32;
      rst64 = 1'b0;
      rst32 = 1'b0;
      tick();
      tick();
      @(posedge clock);
      #2;
      if (use32) rst32 = 1'b1; else rst64 = 1'b1;
      tick();
   endtask

   // runs from a FETCH sample to the retire sample, then steps into the next FETCH
   task automatic exec_one(output logic [63:0] faddr, output int cyc, output int waits, output int pcyc);
      faddr = m_addr; cyc = 1; waits = 0; pcyc = 0;
      forever begin
         if (m_req && !mem_ready) waits++;
         if (m_req && m_addr == probe_addr) pcyc++;
         if (m_retire) break;
         if (cyc >= 60) begin
            checks++; failures++;
            $display("FAIL exec_timeout fetch=%0h got=no retire exp=retire", faddr);
            break;
         end
         tick();
         cyc++;
      end
      tick();
   endtask

   // instruction-level reference: one architectural step, returns zero-wait cycle cost
   task automatic iss_step(output int base);
      logic [31:0] ins;
      logic [63:0] a, b, ii, is, ib, nxt;
      logic [4:0]  rd;
      ins = ref_mem[ref_pc][31:0];
      a = ref_r[ins[19:15]]; b = ref_r[ins[24:20]]; rd = ins[11:7];
      ii = 64'($signed(ins[31:20]));
      is = 64'($signed({ins[31:25], ins[11:7]}));
      ib = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      nxt = ref_pc + 64'd4; base = 4;
      case (ins[6:0])
         7'h33: begin
            if (rd != 5'd0) begin
               if (ins[31:25] == 7'h20)       ref_r[rd] = a - b;
               else if (ins[14:12] == 3'b111) ref_r[rd] = a & b;
               else if (ins[14:12] == 3'b110) ref_r[rd] = a | b;
               else                           ref_r[rd] = a + b;
            end
         end
         7'h13: if (rd != 5'd0) ref_r[rd] = a + ii;
         7'h03: begin base = 5; if (rd != 5'd0) ref_r[rd] = ref_mem[a + ii]; end
         7'h23: ref_mem[a + is] = b;
         7'h63: begin base = 3; if (a == b) nxt = ref_pc + ib; end
         default: base = 0;
      endcase
      ref_pc = nxt;
   endtask

   task automatic test_reset();
      logic [63:0] fa; int c, w, p;
      mem.delete(); fetch_waits = 0; data_waits = 0; data_base = 64'h100; probe_addr = '1;
      mem[64'h0] = {32'b0, enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011)};
      sel32 = 1'b0; rst64 = 1'b0; rst32 = 1'b0;
      tick(); tick();
      checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", m_req); end
      checks++; if (m_retire !== 1'b0 || m_halt !== 1'b0) begin failures++; $display("FAIL rst_ret_halt got=%b%b exp=00", m_retire, m_halt); end
      checks++; if (m_pc !== 64'h0 || m_instret !== 64'h0) begin failures++; $display("FAIL rst_pc_instret got=%0h/%0h exp=0/0", m_pc, m_instret); end
      @(posedge clock); #2; rst64 = 1'b1; tick();
      checks++; if (m_req !== 1'b1 || m_addr !== 64'h0) begin failures++; $display("FAIL first_req got=%b@%0h exp=1@0", m_req, m_addr); end
      exec_one(fa, c, w, p);
      checks++; if (c !== 4) begin failures++; $display("FAIL addi_latency got=%0d exp=4", c); end
      checks++; if (dut64.rf[1] !== 64'd5) begin failures++; $display("FAIL addi_x1 got=%0h exp=5", dut64.rf[1]); end
      checks++; if (m_pc !== 64'h4 || m_instret !== 64'd1) begin failures++; $display("FAIL addi_pc_instret got=%0h/%0h exp=4/1", m_pc, m_instret); end
      rst64 = 1'b0; #1;
      checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL async_req_drop got=%b exp=0", m_req); end
      checks++; if (m_instret !== 64'd0 || dut64.rf[1] !== 64'd0) begin failures++; $display("FAIL async_clear got=%0h/%0h exp=0/0", m_instret, dut64.rf[1]); end
   endtask

   task automatic test_ld_wait();
      logic [63:0] fa; int c, w, p;
      mem.delete(); fetch_waits = 0; data_waits = 3; data_base = 64'h100; probe_addr = 64'h100;
      mem[64'h0] = {32'b0, enc_i(12'h100, 5'd0, 3'b011, 5'd5, 7'b0000011)};
      mem[64'h100] = 64'hDEADBEEF;
      stable_err = 0;
      do_reset(1'b0);
      exec_one(fa, c, w, p);
      checks++; if (c !== 8) begin failures++; $display("FAIL ld_latency got=%0d exp=8", c); end
      checks++; if (p !== 4) begin failures++; $display("FAIL ld_addr_cycles got=%0d exp=4", p); end
      checks++; if (stable_err !== 0) begin failures++; $display("FAIL ld_stable got=%0d exp=0", stable_err); end
      checks++; if (dut64.rf[5] !== 64'hDEADBEEF) begin failures++; $display("FAIL ld_rd got=%0h exp=deadbeef", dut64.rf[5]); end
   endtask

   task automatic test_beq();
      logic [63:0] fa, exp; int c, w, p;
      for (int t = 0; t < 2; t++) begin
         logic [11:0] x2v;
         x2v = (t == 0) ? 12'd7 : 12'd8;
         mem.delete(); fetch_waits = 0; data_waits = 0; data_base = 64'h100; probe_addr = '1;
         mem[64'h0] = {32'b0, enc_i(12'd7, 5'd0, 3'b000, 5'd1, 7'b0010011)};
         mem[64'h4] = {32'b0, enc_i(x2v, 5'd0, 3'b000, 5'd2, 7'b0010011)};
         mem[64'h8] = {32'b0, enc_b(13'd16, 5'd2, 5'd1)};
         do_reset(1'b0);
         exec_one(fa, c, w, p);
         exec_one(fa, c, w, p);
         exec_one(fa, c, w, p);
         exp = (x2v == 12'd7) ? 64'd24 : 64'd12;
         checks++; if (c !== 3) begin failures++; $display("FAIL beq_latency got=%0d exp=3", c); end
         checks++; if (m_req !== 1'b1 || m_addr !== exp) begin failures++; $display("FAIL beq_next got=%0h exp=%0h", m_addr, exp); end
      end
   endtask

   task automatic test_sub_x0();
      logic [63:0] fa; int c, w, p;
      mem.delete(); fetch_waits = -1; data_waits = 0; data_base = 64'h100; probe_addr = '1;
      mem[64'h0] = {32'b0, enc_i(12'd1, 5'd0, 3'b000, 5'd2, 7'b0010011)};
      mem[64'h4] = {32'b0, enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3)};
      mem[64'h8] = {32'b0, enc_i(12'd9, 5'd0, 3'b000, 5'd0, 7'b0010011)};
      mem[64'hC] = {32'b0, enc_r(7'h00, 5'd3, 5'd0, 3'b000, 5'd4)};
      do_reset(1'b0);
      for (int i = 0; i < 4; i++) exec_one(fa, c, w, p);
      checks++; if (dut64.rf[3] !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL sub_x3 got=%0h exp=all ones", dut64.rf[3]); end
      checks++; if (dut64.rf[0] !== 64'h0) begin failures++; $display("FAIL x0_write got=%0h exp=0", dut64.rf[0]); end
      checks++; if (dut64.rf[4] !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL x0_read got=%0h exp=all ones", dut64.rf[4]); end
      checks++; if (m_instret !== 64'd4) begin failures++; $display("FAIL sub_instret got=%0d exp=4", m_instret); end
   endtask

   task automatic test_halt();
      logic [63:0] fa; int c, w, p, nreq;
      mem.delete(); fetch_waits = 0; data_waits = 0; data_base = 64'h100; probe_addr = '1;
      for (int i = 0; i < 8; i++) mem[64'(4 * i)] = {32'b0, enc_i(12'd0, 5'd0, 3'b000, 5'd0, 7'b0010011)};
      mem[64'h20] = 64'h7F;
      do_reset(1'b0);
      for (int i = 0; i < 8; i++) exec_one(fa, c, w, p);
      checks++; if (m_addr !== 64'h20 || m_req !== 1'b1) begin failures++; $display("FAIL halt_fetch got=%0h exp=20", m_addr); end
      tick(); tick();
      checks++; if (m_halt !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", m_halt); end
      checks++; if (m_pc !== 64'h20) begin failures++; $display("FAIL halt_pc got=%0h exp=20", m_pc); end
      nreq = 0;
      for (int i = 0; i < 8; i++) begin if (m_req) nreq++; tick(); end
      checks++; if (nreq !== 0) begin failures++; $display("FAIL halt_noreq got=%0d exp=0", nreq); end
      checks++; if (m_instret !== 64'd8 || m_halt !== 1'b1) begin failures++; $display("FAIL halt_instret got=%0d exp=8", m_instret); end
   endtask

   task automatic test_random();
      logic [63:0] fa; int c, w, p, base;
      mem.delete(); ref_mem.delete();
      fetch_waits = -1; data_waits = -1; data_base = 64'h200; probe_addr = '1; stable_err = 0;
      for (int i = 0; i < 80; i++) begin
         logic [31:0] ins;
         logic [4:0]  rd, rs1, rs2;
         rd  = 5'($urandom_range(0, 7));
         rs1 = 5'($urandom_range(0, 7));
         rs2 = 5'($urandom_range(0, 7));
         case ($urandom_range(0, 4))
            0: case ($urandom_range(0, 3))
                  0: ins = enc_r(7'h00, rs2, rs1, 3'b000, rd);
                  1: ins = enc_r(7'h20, rs2, rs1, 3'b000, rd);
                  2: ins = enc_r(7'h00, rs2, rs1, 3'b111, rd);
                  default: ins = enc_r(7'h00, rs2, rs1, 3'b110, rd);
               endcase
            1: ins = enc_i(12'($urandom), rs1, 3'b000, rd, 7'b0010011);
            2: ins = enc_i(12'(12'h200 + 8 * $urandom_range(0, 15)), 5'd0, 3'b011, rd, 7'b0000011);
            3: ins = enc_s(12'(12'h200 + 8 * $urandom_range(0, 15)), rs2, 5'd0);
            default: ins = enc_b(13'(4 * $urandom_range(1, 3)), rs2, rs1);
         endcase
         mem[64'(4 * i)] = {32'b0, ins};
         ref_mem[64'(4 * i)] = {32'b0, ins};
      end
      for (int j = 0; j < 16; j++) begin
         logic [63:0] d;
         d = {$urandom, $urandom};
         mem[64'h200 + 64'(8 * j)] = d;
         ref_mem[64'h200 + 64'(8 * j)] = d;
      end
      for (int i = 0; i < 32; i++) ref_r[i] = '0;
      ref_pc = '0;
      do_reset(1'b0);
      for (int k = 0; k < 25; k++) begin
         exec_one(fa, c, w, p);
         checks++; if (fa !== ref_pc) begin failures++; $display("FAIL rnd_fetch[%0d] got=%0h exp=%0h", k, fa, ref_pc); end
         iss_step(base);
         checks++; if (c !== base + w) begin failures++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", k, c, base + w); end
      end
      checks++; if (m_addr !== ref_pc) begin failures++; $display("FAIL rnd_final_pc got=%0h exp=%0h", m_addr, ref_pc); end
      checks++; if (m_instret !== 64'd25) begin failures++; $display("FAIL rnd_instret got=%0d exp=25", m_instret); end
      checks++; if (stable_err !== 0) begin failures++; $display("FAIL rnd_stable got=%0d exp=0", stable_err); end
      for (int i = 0; i < 32; i++) begin
         checks++; if (dut64.rf[i] !== ref_r[i]) begin failures++; $display("FAIL rnd_reg[%0d] got=%0h exp=%0h", i, dut64.rf[i], ref_r[i]); end
      end
      for (int j = 0; j < 16; j++) begin
         checks++;
         if (mem[64'h200 + 64'(8 * j)] !== ref_mem[64'h200 + 64'(8 * j)]) begin
            failures++;
            $display("FAIL rnd_mem[%0d] got=%0h exp=%0h", j, mem[64'h200 + 64'(8 * j)], ref_mem[64'h200 + 64'(8 * j)]);
         end
      end
   endtask

   task automatic test_xlen32();
      logic [63:0] fa; int c, w, p;
      mem.delete(); fetch_waits = -1; data_waits = -1; data_base = 64'h40; probe_addr = '1; stable_err = 0;
      mem[64'h0]  = {32'b0, enc_i(12'h048, 5'd0, 3'b011, 5'd9, 7'b0000011)};
      mem[64'h4]  = {32'b0, enc_s(12'h040, 5'd17, 5'd0)};
      mem[64'h8]  = {32'b0, enc_i(12'h040, 5'd0, 3'b011, 5'd2, 7'b0000011)};
      mem[64'hC]  = {32'b0, enc_i(12'd1, 5'd3, 3'b000, 5'd3, 7'b0010011)};
      mem[64'h10] = {32'b0, enc_i(12'd1, 5'd3, 3'b000, 5'd3, 7'b0010011)};
      mem[64'h48] = 64'h8000_0001;
      do_reset(1'b1);
      for (int i = 0; i < 3; i++) exec_one(fa, c, w, p);
      checks++; if (dut32.rf[1] !== 32'h8000_0001) begin failures++; $display("FAIL x32_ld_mod got=%0h exp=80000001", dut32.rf[1]); end
      checks++; if (mem[64'h40] !== 64'h8000_0001) begin failures++; $display("FAIL x32_sd got=%0h exp=80000001", mem[64'h40]); end
      checks++; if (dut32.rf[2] !== 32'h8000_0001) begin failures++; $display("FAIL x32_roundtrip got=%0h exp=80000001", dut32.rf[2]); end
      checks++; if (m_instret !== 64'd3) begin failures++; $display("FAIL x32_instret got=%0d exp=3", m_instret); end
      force dut32.instret = 32'hFFFF_FFFF;
      #1;
      release dut32.instret;
      exec_one(fa, c, w, p);
      checks++; if (m_instret !== 64'd0) begin failures++; $display("FAIL x32_wrap got=%0h exp=0", m_instret); end
      exec_one(fa, c, w, p);
      checks++; if (m_instret !== 64'd1) begin failures++; $display("FAIL x32_after_wrap got=%0h exp=1", m_instret); end
      checks++; if (dut32.rf[3] !== 32'd2) begin failures++; $display("FAIL x32_addi got=%0h exp=2", dut32.rf[3]); end
   endtask

   initial begin
      test_reset();
      test_ld_wait();
      test_beq();
      test_sub_x0();
      test_halt();
      test_random();
      test_xlen32();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
